// File: rtl/ls_pkg.sv
// Shared encodings for the RV32I load/store sequencer: opcodes, funct3 sizes, FSM states, trap causes.
// No logic; imported by the lane unit and the sequencer.
package ls_pkg;

    localparam int LANES = 4;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_NONE       = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_FINISH = 2'b10,
        S_TRAP   = 2'b11
    } state_t;

endpackage

// File: rtl/load_store_sequencer_if.sv
// Data-memory request port of the load/store sequencer: request/ready handshake plus data lanes.
// The sequencer holds mem_req until the memory returns mem_ready.
interface load_store_sequencer_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;

    modport master (
        output mem_req, mem_we, mem_be, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/ls_lane_unit.sv
// Byte-lane logic: byte enables, store replication, load extraction/extension, fault flags.
// Purely combinational, zero latency, no backpressure.
module ls_lane_unit
    import ls_pkg::*;
(
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};

        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase

        case (funct3_i)
            F3_B:    ldata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ldata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ldata_o = {24'h0, shifted[7:0]};
            F3_HU:   ldata_o = {16'h0, shifted[15:0]};
            default: ldata_o = shifted;
        endcase

        // Stores only have B/H/W; loads additionally allow BU/HU.
        if (is_store_i)
            illegal_o = (funct3_i > F3_W);
        else
            illegal_o = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);

        misaligned_o = ((funct3_i[1:0] == 2'b01) && off_i[0]) ||
                       ((funct3_i[1:0] == 2'b10) && (off_i != 2'b00));
    end

endmodule

// File: rtl/load_store_sequencer.sv
// Multi-cycle RV32I load/store control: IDLE -> ACCESS -> FINISH, faults park in TRAP until trap_ack.
// Aligned access with immediate mem_ready gives done 2 cycles after start; waits on mem_ready up to MAX_WAIT.
module load_store_sequencer
    import ls_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
)(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           INSN,
    input  logic                  start,
    input  logic [XLEN-1:0]       alu_addr,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic                  trap_ack,
    load_store_sequencer_if.master mem,
    output logic                  addr_sel,
    output logic                  sub_sra,
    output logic                  pc_next_sel,
    output logic                  pc_alu_sel,
    output logic                  rd_we,
    output logic [XLEN-1:0]       rd_data,
    output logic                  pc_stall,
    output logic                  busy,
    output logic                  done,
    output logic                  trap,
    output logic [1:0]            trap_cause
);

    state_t            state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;
    logic [1:0]        cause_q, cause_d;

    logic [6:0]  opcode;
    logic        is_ls_op;
    logic        lu_store;
    logic [2:0]  lu_funct3;
    logic [1:0]  lu_off;
    logic [3:0]  lu_be;
    logic [31:0] lu_wdata;
    logic [31:0] lu_ldata;
    logic        lu_misaligned;
    logic        lu_illegal;
    logic        unused_ok;

    assign opcode    = INSN[6:0];
    assign is_ls_op  = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign unused_ok = ^{INSN[31:15], INSN[11:7], alu_addr[XLEN-1:2]};

    // In IDLE the lane unit classifies the incoming instruction; afterwards it works on the latched fields.
    always_comb begin
        if (state_q == S_IDLE) begin
            lu_store  = (opcode == OP_STORE);
            lu_funct3 = INSN[14:12];
            lu_off    = alu_addr[1:0];
        end else begin
            lu_store  = is_store_q;
            lu_funct3 = funct3_q;
            lu_off    = off_q;
        end
    end

    ls_lane_unit u_lane (
        .is_store_i   (lu_store),
        .funct3_i     (lu_funct3),
        .off_i        (lu_off),
        .wdata_i      (wdata_q),
        .rdata_i      (mem.mem_rdata),
        .be_o         (lu_be),
        .wdata_o      (lu_wdata),
        .ldata_o      (lu_ldata),
        .misaligned_o (lu_misaligned),
        .illegal_o    (lu_illegal)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            wdata_q    <= '0;
            wait_q     <= '0;
            rd_data_q  <= '0;
            cause_q    <= CAUSE_NONE;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            wait_q     <= wait_d;
            rd_data_q  <= rd_data_d;
            cause_q    <= cause_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        wait_d     = wait_q;
        rd_data_d  = rd_data_q;
        cause_d    = cause_q;

        case (state_q)
            S_IDLE: begin
                if (start && is_ls_op) begin
                    is_store_d = (opcode == OP_STORE);
                    funct3_d   = INSN[14:12];
                    off_d      = alu_addr[1:0];
                    wdata_d    = rs2_data;
                    wait_d     = '0;
                    if (lu_illegal) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end else if (lu_misaligned) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_MISALIGNED;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                // mem_ready has priority over an expiring wait budget.
                if (mem.mem_ready) begin
                    state_d = S_FINISH;
                    if (!is_store_q)
                        rd_data_d = lu_ldata;
                end else if ((MAX_WAIT != 0) && (wait_q == WAIT_W'(MAX_WAIT))) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            S_TRAP: begin
                if (trap_ack) begin
                    state_d = S_IDLE;
                    cause_d = CAUSE_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_be    = 4'b0000;
        mem.mem_wdata = '0;
        addr_sel      = 1'b0;
        rd_we         = 1'b0;
        pc_stall      = 1'b0;
        done          = 1'b0;
        trap          = 1'b0;

        case (state_q)
            S_ACCESS: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = is_store_q;
                mem.mem_be    = lu_be;
                mem.mem_wdata = lu_wdata;
                addr_sel      = 1'b1;
                pc_stall      = 1'b1;
            end
            S_FINISH: begin
                done  = 1'b1;
                rd_we = !is_store_q;
            end
            S_TRAP: begin
                trap     = 1'b1;
                pc_stall = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign sub_sra     = 1'b0;
    assign pc_next_sel = 1'b0;
    assign pc_alu_sel  = 1'b0;
    assign rd_data     = rd_data_q;
    assign trap_cause  = cause_q;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer with MAX_WAIT=3; expected values are hand-derived.
module tb_load_store_sequencer;

    logic        CLK;
    logic        RST;
    logic [31:0] INSN;
    logic        start;
    logic [31:0] alu_addr;
    logic [31:0] rs2_data;
    logic        trap_ack;
    logic        addr_sel, sub_sra, pc_next_sel, pc_alu_sel, rd_we;
    logic [31:0] rd_data;
    logic        pc_stall, busy, done, trap;
    logic [1:0]  trap_cause;

    int n_chk  = 0;
    int n_pass = 0;

    load_store_sequencer_if #(.XLEN(32)) mif ();

    load_store_sequencer #(
        .XLEN     (32),
        .MAX_WAIT (3),
        .WAIT_W   (4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .INSN        (INSN),
        .start       (start),
        .alu_addr    (alu_addr),
        .rs2_data    (rs2_data),
        .trap_ack    (trap_ack),
        .mem         (mif),
        .addr_sel    (addr_sel),
        .sub_sra     (sub_sra),
        .pc_next_sel (pc_next_sel),
        .pc_alu_sel  (pc_alu_sel),
        .rd_we       (rd_we),
        .rd_data     (rd_data),
        .pc_stall    (pc_stall),
        .busy        (busy),
        .done        (done),
        .trap        (trap),
        .trap_cause  (trap_cause)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] ld_insn(input logic [2:0] f3);
        return {12'h000, 5'd1, f3, 5'd2, 7'b0000011};
    endfunction

    function automatic logic [31:0] st_insn(input logic [2:0] f3);
        return {7'h00, 5'd2, 5'd1, f3, 5'd0, 7'b0100011};
    endfunction

    task automatic issue(input logic [31:0] insn, input logic [31:0] addr, input logic [31:0] rs2);
        INSN     = insn;
        alu_addr = addr;
        rs2_data = rs2;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic ack_trap();
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
    endtask

    initial begin
        RST           = 1'b1;
        INSN          = 32'h0;
        start         = 1'b0;
        alu_addr      = 32'h0;
        rs2_data      = 32'h0;
        trap_ack      = 1'b0;
        mif.mem_rdata = 32'h0;
        mif.mem_ready = 1'b0;
        tick();
        tick();

        chk("rst_busy",  32'(busy),       32'h0);
        chk("rst_req",   32'(mif.mem_req), 32'h0);
        chk("rst_be",    32'(mif.mem_be),  32'h0);
        chk("rst_wdata", mif.mem_wdata,    32'h0);
        chk("rst_rd",    rd_data,          32'h0);
        chk("rst_cause", 32'(trap_cause),  32'h0);
        chk("rst_const", 32'({sub_sra, pc_next_sel, pc_alu_sel}), 32'h0);
        RST = 1'b0;
        tick();

        // LB @0x103: byte 0x80 sign-extends; ready in the first ACCESS cycle
        mif.mem_rdata = 32'h80112233;
        mif.mem_ready = 1'b1;
        issue(ld_insn(3'b000), 32'h103, 32'h0);
        chk("lb_acc", 32'({mif.mem_req, mif.mem_we, addr_sel, pc_stall, busy, done}), 32'b101110);
        chk("lb_be",  32'(mif.mem_be), 32'b1000);
        tick();
        chk("lb_done", 32'({done, rd_we, pc_stall, addr_sel}), 32'b1100);
        chk("lb_data", rd_data, 32'hFFFFFF80);
        tick();
        chk("lb_after", 32'({done, rd_we, busy}), 32'b000);

        // LHU @0x102: upper half zero-extended
        mif.mem_rdata = 32'hBEEF1234;
        issue(ld_insn(3'b101), 32'h102, 32'h0);
        chk("lhu_be", 32'(mif.mem_be), 32'b1100);
        tick();
        chk("lhu_data", rd_data, 32'h0000BEEF);
        tick();

        // LH @0x100: low half 0x8001 sign-extends
        mif.mem_rdata = 32'h12348001;
        issue(ld_insn(3'b001), 32'h100, 32'h0);
        tick();
        chk("lh_data", rd_data, 32'hFFFF8001);
        tick();

        // SH @0x102: memory stalls one cycle; rd_we never asserted
        mif.mem_ready = 1'b0;
        issue(st_insn(3'b001), 32'h102, 32'hAAAA5555);
        chk("sh_be",    32'(mif.mem_be), 32'b1100);
        chk("sh_wdata", mif.mem_wdata,   32'h55555555);
        chk("sh_we",    32'({mif.mem_req, mif.mem_we, rd_we}), 32'b110);
        mif.mem_ready = 1'b1;
        tick();
        chk("sh_done", 32'({done, rd_we}), 32'b10);
        chk("sh_rd_keep", rd_data, 32'hFFFF8001);
        tick();

        // SB @0x101: byte replicated on all lanes
        issue(st_insn(3'b000), 32'h101, 32'h12345678);
        chk("sb_be",    32'(mif.mem_be), 32'b0010);
        chk("sb_wdata", mif.mem_wdata,   32'h78787878);
        tick();
        tick();

        // LW @0x201: misaligned, no memory request
        issue(ld_insn(3'b010), 32'h201, 32'h0);
        chk("mis_trap", 32'({trap, mif.mem_req, pc_stall, busy, rd_we}), 32'b10110);
        chk("mis_cause", 32'(trap_cause), 32'h1);
        tick();
        chk("mis_hold", 32'({trap, mif.mem_req}), 32'b10);
        ack_trap();
        chk("mis_ack", 32'({busy, trap, trap_cause}), 32'h0);

        // Load funct3 110: illegal
        issue(ld_insn(3'b110), 32'h100, 32'h0);
        chk("ill_cause", 32'({trap, trap_cause}), 32'b110);
        ack_trap();
        chk("ill_ack", 32'({busy, trap_cause}), 32'h0);

        // Store funct3 100: illegal for stores
        issue(st_insn(3'b100), 32'h100, 32'h0);
        chk("ill_st_cause", 32'(trap_cause), 32'h2);
        ack_trap();

        // R-type opcode ignored
        issue(32'h002081B3, 32'h100, 32'h0);
        chk("rtype_idle", 32'({busy, mif.mem_req}), 32'h0);

        // Timeout: ready held low, trap after the 4th ACCESS cycle
        mif.mem_ready = 1'b0;
        issue(ld_insn(3'b010), 32'h200, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("to_wait", 32'({mif.mem_req, trap}), 32'b10);
            tick();
        end
        chk("to_last", 32'({mif.mem_req, trap}), 32'b10);
        tick();
        chk("to_trap", 32'({trap, trap_cause, mif.mem_req, done}), 32'b11100);
        ack_trap();

        // Ready in the 4th ACCESS cycle beats the timeout
        mif.mem_rdata = 32'hDEADBEEF;
        issue(ld_insn(3'b010), 32'h200, 32'h0);
        tick();
        tick();
        tick();
        mif.mem_ready = 1'b1;
        tick();
        chk("late_done", 32'({done, trap, trap_cause}), 32'b1000);
        chk("late_data", rd_data, 32'hDEADBEEF);
        tick();

        // Start during ACCESS is ignored; RST in the 2nd ACCESS cycle aborts cleanly
        mif.mem_ready = 1'b0;
        issue(ld_insn(3'b000), 32'h101, 32'h0);
        INSN     = st_insn(3'b010);
        alu_addr = 32'h300;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("busy_start", 32'({mif.mem_req, mif.mem_we, mif.mem_be}), 32'b100010);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort_out", 32'({mif.mem_req, mif.mem_we, mif.mem_be, addr_sel, rd_we, pc_stall, busy, done, trap, trap_cause}), 32'h0);
        chk("abort_rd",    rd_data,       32'h0);
        chk("abort_wdata", mif.mem_wdata, 32'h0);
        tick();
        chk("abort_nodone", 32'({done, trap, busy}), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
